// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// mem_stage_ctrl : RV32I memory-stage controller (IDLE/BUSY/DONE handshake,
//                  store lane steering, load extraction and extension)
// Revision 1.0
// ============================================================================

package rv32i_types;
   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic [3:0] wmask;
   } MEM_ctrl_t;
endpackage

module mem_stage_ctrl
   import rv32i_types::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_i,
   input  MEM_ctrl_t   mem_ctrl_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] store_data_i,
   output logic [31:0] dmem_address_o,
   output logic        dmem_read_o,
   output logic        dmem_write_o,
   output logic [3:0]  dmem_wmask_o,
   output logic [31:0] dmem_wdata_o,
   input  logic [31:0] dmem_rdata_i,
   input  logic        dmem_resp_i,
   output logic [31:0] load_data_o,
   output logic        load_valid_o,
   output logic        stall_o,
   output logic        misaligned_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   logic [1:0]  off;
   logic        is_byte;
   logic        is_half;
   logic        is_word;
   logic        want_read;
   logic        want_write;
   logic        access;
   logic        misaligned;
   logic        request;
   logic [3:0]  wmask_next;
   logic [31:0] wdata_next;
   logic        lat_read;
   logic [2:0]  lat_funct3;
   logic [1:0]  lat_off;
   logic [7:0]  rbyte;
   logic [15:0] rhalf;
   logic [31:0] load_ext;
   logic        unused_wmask;

   // The decode-stage mask is recomputed here from funct3 and the byte offset.
   assign unused_wmask = ^mem_ctrl_i.wmask;

   always_comb begin
      off        = addr_i[1:0];
      is_byte    = (funct3_i[1:0] == 2'b00);
      is_half    = (funct3_i[1:0] == 2'b01);
      is_word    = funct3_i[1];
      want_read  = mem_ctrl_i.mem_read;
      want_write = mem_ctrl_i.mem_write & ~mem_ctrl_i.mem_read;
      access     = valid_i & (want_read | want_write);
      misaligned = access & ((is_half & off[0]) | (is_word & (off != 2'b00)));
      request    = access & ~misaligned;
      wmask_next = 4'b0000;
      wdata_next = 32'h0;
      if (want_write) begin
         if (is_byte) begin
            wmask_next = 4'b0001 << off;
            wdata_next = {24'h0, store_data_i[7:0]} << {off, 3'b000};
         end else if (is_half) begin
            wmask_next = 4'b0011 << off;
            wdata_next = {16'h0, store_data_i[15:0]} << {off, 3'b000};
         end else begin
            wmask_next = 4'b1111;
            wdata_next = store_data_i;
         end
      end
   end

   always_comb begin
      rbyte = dmem_rdata_i[{lat_off, 3'b000} +: 8];
      rhalf = lat_off[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
      case (lat_funct3)
         3'b000:  load_ext = {{24{rbyte[7]}}, rbyte};
         3'b001:  load_ext = {{16{rhalf[15]}}, rhalf};
         3'b100:  load_ext = {24'h0, rbyte};
         3'b101:  load_ext = {16'h0, rhalf};
         default: load_ext = dmem_rdata_i;
      endcase
   end

   assign stall_o      = ~rst & (((state == IDLE) & request) | (state == BUSY));
   assign misaligned_o = ~rst & (state == IDLE) & misaligned;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         dmem_address_o <= 32'h0;
         dmem_read_o    <= 1'b0;
         dmem_write_o   <= 1'b0;
         dmem_wmask_o   <= 4'b0000;
         dmem_wdata_o   <= 32'h0;
         load_data_o    <= 32'h0;
         load_valid_o   <= 1'b0;
         lat_read       <= 1'b0;
         lat_funct3     <= 3'b000;
         lat_off        <= 2'b00;
      end else begin
         load_valid_o <= 1'b0;
         case (state)
            IDLE: begin
               if (request) begin
                  dmem_address_o <= {addr_i[31:2], 2'b00};
                  dmem_read_o    <= want_read;
                  dmem_write_o   <= want_write;
                  dmem_wmask_o   <= wmask_next;
                  dmem_wdata_o   <= wdata_next;
                  lat_read       <= want_read;
                  lat_funct3     <= funct3_i;
                  lat_off        <= off;
                  state          <= BUSY;
               end
            end
            BUSY: begin
               if (dmem_resp_i) begin
                  dmem_read_o  <= 1'b0;
                  dmem_write_o <= 1'b0;
                  if (lat_read) begin
                     load_data_o  <= load_ext;
                     load_valid_o <= 1'b1;
                  end
                  state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mem_stage_ctrl : scoreboard bench for mem_stage_ctrl
// Revision 1.0
// ============================================================================
module tb_mem_stage_ctrl;
   import rv32i_types::*;

   typedef struct packed {
      logic [31:0] addr;
      logic        rd;
      logic        wr;
      logic [3:0]  wmask;
      logic [31:0] wdata;
   } req_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i;
   MEM_ctrl_t   mem_ctrl_i;
   logic [2:0]  funct3_i;
   logic [31:0] addr_i;
   logic [31:0] store_data_i;
   logic [31:0] dmem_address_o;
   logic        dmem_read_o;
   logic        dmem_write_o;
   logic [3:0]  dmem_wmask_o;
   logic [31:0] dmem_wdata_o;
   logic [31:0] dmem_rdata_i;
   logic        dmem_resp_i;
   logic [31:0] load_data_o;
   logic        load_valid_o;
   logic        stall_o;
   logic        misaligned_o;

   int          passed = 0;
   int          total  = 0;
   logic [31:0] last_load = 32'h0;
   logic [31:0] exp_load_q[$];
   req_t        exp_req_q[$];

   always #5 clk = ~clk;

   mem_stage_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .valid_i        (valid_i),
      .mem_ctrl_i     (mem_ctrl_i),
      .funct3_i       (funct3_i),
      .addr_i         (addr_i),
      .store_data_i   (store_data_i),
      .dmem_address_o (dmem_address_o),
      .dmem_read_o    (dmem_read_o),
      .dmem_write_o   (dmem_write_o),
      .dmem_wmask_o   (dmem_wmask_o),
      .dmem_wdata_o   (dmem_wdata_o),
      .dmem_rdata_i   (dmem_rdata_i),
      .dmem_resp_i    (dmem_resp_i),
      .load_data_o    (load_data_o),
      .load_valid_o   (load_valid_o),
      .stall_o        (stall_o),
      .misaligned_o   (misaligned_o)
   );

   task automatic drive(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd);
      valid_i             = v;
      mem_ctrl_i.mem_read  = rd;
      mem_ctrl_i.mem_write = wr;
      mem_ctrl_i.wmask     = 4'b1010;
      funct3_i            = f3;
      addr_i              = a;
      store_data_i        = sd;
   endtask

   // Entered and left at posedge+1; the instruction stays on the inputs
   // until the caller drives the next one.
   task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] sd,
                             input logic [31:0] rdata, input int k,
                             output req_t seen, output int stalls, output int strobes,
                             output logic lv, output logic [31:0] ld);
      drive(1'b1, rd, wr, f3, a, sd);
      stalls = 0; strobes = 0; seen = '0;
      @(negedge clk);
      if (stall_o) stalls++;
      for (int i = 1; i <= k; i++) begin
         @(posedge clk); #1;
         if (i == k) begin dmem_resp_i = 1'b1; dmem_rdata_i = rdata; end
         @(negedge clk);
         if (i == 1) seen = '{addr: dmem_address_o, rd: dmem_read_o, wr: dmem_write_o,
                              wmask: dmem_wmask_o, wdata: dmem_wdata_o};
         if (dmem_read_o | dmem_write_o) strobes++;
         if (stall_o) stalls++;
      end
      @(posedge clk); #1;
      dmem_resp_i  = 1'b0;
      dmem_rdata_i = 32'h0;
      @(negedge clk);
      lv = load_valid_o;
      ld = load_data_o;
      if (stall_o) stalls++;
      if (dmem_read_o | dmem_write_o) strobes++;
      @(posedge clk); #1;
   endtask

   task automatic go_idle();
      drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      dmem_resp_i = 1'b0; dmem_rdata_i = 32'h0;
      drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      if ({dmem_read_o, dmem_write_o, dmem_wmask_o, dmem_wdata_o, dmem_address_o} !== '0)
         $display("FAIL reset_dmem: got rd=%b wr=%b m=%b wd=%h a=%h want all 0",
                  dmem_read_o, dmem_write_o, dmem_wmask_o, dmem_wdata_o, dmem_address_o);
      else passed++;
      total++;
      if ({load_valid_o, load_data_o} !== '0)
         $display("FAIL reset_load: got lv=%b ld=%h want 0", load_valid_o, load_data_o);
      else passed++;
      total++;
      if ({stall_o, misaligned_o} !== 2'b00)
         $display("FAIL reset_stall: got stall=%b mis=%b want 0", stall_o, misaligned_o);
      else passed++;
      @(posedge clk); #1;
      rst = 1'b0;
      go_idle();
   endtask

   task automatic test_lw();
      req_t r, e; int st, sb; logic lv; logic [31:0] ld;
      exp_req_q.push_back('{addr: 32'h0000_1008, rd: 1'b1, wr: 1'b0, wmask: 4'b0000, wdata: 32'h0});
      exp_load_q.push_back(32'hDEAD_BEEF);
      last_load = 32'hDEAD_BEEF;
      run_access(1'b1, 1'b0, 3'b010, 32'h0000_1008, 32'h5555_5555, 32'hDEAD_BEEF, 3,
                 r, st, sb, lv, ld);
      go_idle();
      e = exp_req_q.pop_front();
      total++;
      if (r !== e) $display("FAIL lw_request: got %h want %h", r, e); else passed++;
      total++;
      if (sb !== 3) $display("FAIL lw_strobe_cycles: got %0d want 3", sb); else passed++;
      total++;
      if (st !== 4) $display("FAIL lw_stall_cycles: got %0d want 4", st); else passed++;
      total++;
      if (lv !== 1'b1) $display("FAIL lw_load_valid: got %b want 1", lv); else passed++;
      total++;
      if (ld !== exp_load_q.pop_front()) $display("FAIL lw_load_data: got %h want deadbeef", ld);
      else passed++;
      @(negedge clk);
      total++;
      if (load_valid_o !== 1'b0) $display("FAIL lw_valid_pulse: got %b want 0", load_valid_o);
      else passed++;
      @(posedge clk); #1;
   endtask

   task automatic test_loads();
      logic [2:0]  f3s [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b011};
      logic [31:0] as  [5] = '{32'h0000_1003, 32'h0000_1003, 32'h0000_1002, 32'h0000_1002, 32'h0000_1004};
      logic [31:0] exs [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF, 32'h80FF_0000};
      req_t r, e; int st, sb; logic lv; logic [31:0] ld, x;
      for (int i = 0; i < 5; i++) begin
         exp_req_q.push_back('{addr: {as[i][31:2], 2'b00}, rd: 1'b1, wr: 1'b0, wmask: 4'b0000, wdata: 32'h0});
         exp_load_q.push_back(exs[i]);
         last_load = exs[i];
         run_access(1'b1, 1'b0, f3s[i], as[i], 32'h0, 32'h80FF_0000, 1, r, st, sb, lv, ld);
         go_idle();
         e = exp_req_q.pop_front();
         x = exp_load_q.pop_front();
         total++;
         if (r !== e) $display("FAIL load%0d_request: got %h want %h", i, r, e); else passed++;
         total++;
         if ({lv, ld} !== {1'b1, x})
            $display("FAIL load%0d_data: got lv=%b %h want lv=1 %h", i, lv, ld, x);
         else passed++;
         total++;
         if (st !== 2 || sb !== 1)
            $display("FAIL load%0d_timing: got stall=%0d strobe=%0d want 2 1", i, st, sb);
         else passed++;
      end
   endtask

   task automatic test_store();
      req_t r, e; int st, sb; logic lv; logic [31:0] ld;
      exp_req_q.push_back('{addr: 32'h0000_2000, rd: 1'b0, wr: 1'b1, wmask: 4'b1100, wdata: 32'hABCD_0000});
      run_access(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 2, r, st, sb, lv, ld);
      go_idle();
      e = exp_req_q.pop_front();
      total++;
      if (r !== e) $display("FAIL sh_request: got %h want %h", r, e); else passed++;
      total++;
      if (sb !== 2 || st !== 3)
         $display("FAIL sh_timing: got strobe=%0d stall=%0d want 2 3", sb, st);
      else passed++;
      total++;
      if (lv !== 1'b0 || ld !== last_load)
         $display("FAIL sh_no_load: got lv=%b ld=%h want lv=0 ld=%h", lv, ld, last_load);
      else passed++;
      // read and write both set: treated as a read
      exp_req_q.push_back('{addr: 32'h0000_2004, rd: 1'b1, wr: 1'b0, wmask: 4'b0000, wdata: 32'h0});
      last_load = 32'h0102_0304;
      run_access(1'b1, 1'b1, 3'b010, 32'h0000_2004, 32'hFFFF_FFFF, 32'h0102_0304, 1, r, st, sb, lv, ld);
      go_idle();
      e = exp_req_q.pop_front();
      total++;
      if (r !== e || lv !== 1'b1 || ld !== 32'h0102_0304)
         $display("FAIL rdwr_is_read: got %h lv=%b ld=%h want %h lv=1 ld=01020304", r, lv, ld, e);
      else passed++;
   endtask

   task automatic test_misaligned();
      logic [2:0] f3s [2] = '{3'b010, 3'b101};
      logic       wrs [2] = '{1'b1, 1'b0};
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, ~wrs[i], wrs[i], f3s[i], 32'h0000_3001, 32'hCAFE_F00D);
         for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if ({misaligned_o, stall_o, dmem_read_o, dmem_write_o, load_valid_o} !== 5'b10000)
               $display("FAIL misaligned%0d_c%0d: got mis=%b stall=%b rd=%b wr=%b lv=%b want 1 0 0 0 0",
                        i, c, misaligned_o, stall_o, dmem_read_o, dmem_write_o, load_valid_o);
            else passed++;
            @(posedge clk); #1;
         end
         total++;
         if (load_data_o !== last_load)
            $display("FAIL misaligned%0d_load_kept: got %h want %h", i, load_data_o, last_load);
         else passed++;
      end
      go_idle();
   endtask

   task automatic test_reset_in_busy();
      req_t r, e; int st, sb; logic lv; logic [31:0] ld;
      drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_1008, 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (dmem_read_o !== 1'b1) $display("FAIL abort_busy_read: got %b want 1", dmem_read_o);
      else passed++;
      #1 rst = 1'b1;
      #1;
      total++;
      if ({dmem_read_o, dmem_write_o, dmem_address_o, stall_o, misaligned_o, load_valid_o, load_data_o} !== '0)
         $display("FAIL abort_async_clear: got rd=%b a=%h stall=%b lv=%b ld=%h want 0",
                  dmem_read_o, dmem_address_o, stall_o, load_valid_o, load_data_o);
      else passed++;
      last_load = 32'h0;
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      rst = 1'b0;
      dmem_resp_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      dmem_resp_i = 1'b0; dmem_rdata_i = 32'h0;
      @(negedge clk);
      total++;
      if ({load_valid_o, load_data_o, dmem_read_o, dmem_write_o, stall_o} !== '0)
         $display("FAIL stray_resp: got lv=%b ld=%h rd=%b wr=%b stall=%b want 0",
                  load_valid_o, load_data_o, dmem_read_o, dmem_write_o, stall_o);
      else passed++;
      @(posedge clk); #1;
      exp_req_q.push_back('{addr: 32'h0000_4000, rd: 1'b0, wr: 1'b1, wmask: 4'b0010, wdata: 32'h0000_EF00});
      run_access(1'b0, 1'b1, 3'b000, 32'h0000_4001, 32'h1234_56EF, 32'h0, 1, r, st, sb, lv, ld);
      go_idle();
      e = exp_req_q.pop_front();
      total++;
      if (r !== e || lv !== 1'b0) $display("FAIL sb_after_reset: got %h lv=%b want %h lv=0", r, lv, e);
      else passed++;
   endtask

   task automatic test_non_mem();
      drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_1000, 32'h0);
      repeat (2) begin
         @(negedge clk);
         total++;
         if ({stall_o, dmem_read_o, dmem_write_o} !== 3'b000)
            $display("FAIL invalid_read: got stall=%b rd=%b wr=%b want 0", stall_o, dmem_read_o, dmem_write_o);
         else passed++;
         @(posedge clk); #1;
      end
      drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_1001, 32'h0);
      repeat (2) begin
         @(negedge clk);
         total++;
         if ({stall_o, dmem_read_o, dmem_write_o, misaligned_o, load_valid_o} !== 5'b00000)
            $display("FAIL op_reg_pass: got stall=%b rd=%b wr=%b mis=%b lv=%b want 0",
                     stall_o, dmem_read_o, dmem_write_o, misaligned_o, load_valid_o);
         else passed++;
         @(posedge clk); #1;
      end
      go_idle();
   endtask

   task automatic test_back_to_back();
      req_t r1, r2, e; int st1, st2, sb1, sb2; logic lv1, lv2; logic [31:0] ld1, ld2;
      exp_req_q.push_back('{addr: 32'h0000_5000, rd: 1'b1, wr: 1'b0, wmask: 4'b0000, wdata: 32'h0});
      exp_req_q.push_back('{addr: 32'h0000_5000, rd: 1'b1, wr: 1'b0, wmask: 4'b0000, wdata: 32'h0});
      exp_load_q.push_back(32'h1111_1111);
      exp_load_q.push_back(32'h0000_00AB);
      run_access(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'h0, 32'h1111_1111, 1, r1, st1, sb1, lv1, ld1);
      run_access(1'b1, 1'b0, 3'b100, 32'h0000_5001, 32'h0, 32'h0000_AB00, 1, r2, st2, sb2, lv2, ld2);
      go_idle();
      e = exp_req_q.pop_front();
      total++;
      if (r1 !== e || {lv1, ld1} !== {1'b1, exp_load_q.pop_front()})
         $display("FAIL b2b_first: got %h lv=%b ld=%h want %h lv=1 ld=11111111", r1, lv1, ld1, e);
      else passed++;
      e = exp_req_q.pop_front();
      total++;
      if (r2 !== e || {lv2, ld2} !== {1'b1, exp_load_q.pop_front()})
         $display("FAIL b2b_second: got %h lv=%b ld=%h want %h lv=1 ld=000000ab", r2, lv2, ld2, e);
      else passed++;
      total++;
      if (st1 !== 2 || st2 !== 2 || sb1 !== 1 || sb2 !== 1)
         $display("FAIL b2b_timing: got stall=%0d,%0d strobe=%0d,%0d want 2,2 1,1", st1, st2, sb1, sb2);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_lw();
      test_loads();
      test_store();
      test_misaligned();
      test_reset_in_busy();
      test_non_mem();
      test_back_to_back();
      total++;
      if (exp_req_q.size() != 0 || exp_load_q.size() != 0)
         $display("FAIL scoreboard_drained: got req=%0d load=%0d want 0 0", exp_req_q.size(), exp_load_q.size());
      else passed++;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
